// File: rtl/conv_seq_pkg.sv
`default_nettype none
// =============================================================================
// Module : conv_seq_pkg
// Brief  : Shared state encoding and default sizing for the conv tile sequencer.
// Rev    : 1.0
// =============================================================================
package conv_seq_pkg;

  localparam int DEF_NUM_PE = 9;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_K_CYC  = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_W  = 3'd1,
    ST_LOAD_IN = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_e;

  // A one-cycle burst still needs a 1-bit counter.
  function automatic int kc_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_tile_sequencer_tile_counter_chain.sv
`default_nettype none
// =============================================================================
// Module : tile_counter_chain
// Brief  : Four nested wrap counters (w innermost, oc outermost) with last flags.
// Rev    : 1.0
// =============================================================================
module tile_counter_chain
  import conv_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] cnt_w_i,
  input  logic [CNT_W-1:0] cnt_h_i,
  input  logic [CNT_W-1:0] cnt_ic_i,
  input  logic [CNT_W-1:0] cnt_oc_i,
  output logic [CNT_W-1:0] w_idx_o,
  output logic [CNT_W-1:0] h_idx_o,
  output logic [CNT_W-1:0] ic_idx_o,
  output logic [CNT_W-1:0] oc_idx_o,
  output logic             w_last_o,
  output logic             h_last_o,
  output logic             ic_last_o,
  output logic             oc_last_o
);

  // Slot 0 = w, 1 = h, 2 = ic, 3 = oc.
  logic [3:0][CNT_W-1:0] idx_q;
  logic [3:0][CNT_W-1:0] idx_d;
  logic [3:0][CNT_W-1:0] max_q;
  logic [3:0][CNT_W-1:0] max_d;
  logic [3:0][CNT_W-1:0] cnt_in;
  logic [3:0]            last;

  assign cnt_in = {cnt_oc_i, cnt_ic_i, cnt_h_i, cnt_w_i};

  // Store the highest index rather than the count; a zero count behaves as one.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      max_d[i] = (cnt_in[i] == '0) ? '0 : (cnt_in[i] - CNT_W'(1));
      last[i]  = (idx_q[i] == max_q[i]);
    end
  end

  always_comb begin
    logic carry;
    carry = inc_i && !(&last);
    for (int i = 0; i < 4; i++) begin
      idx_d[i] = idx_q[i];
      if (carry) begin
        if (last[i]) begin
          idx_d[i] = '0;
        end else begin
          idx_d[i] = idx_q[i] + CNT_W'(1);
        end
        carry = last[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      idx_q <= '0;
      max_q <= '0;
    end else if (load_i) begin
      idx_q <= '0;
      max_q <= max_d;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign w_idx_o   = idx_q[0];
  assign h_idx_o   = idx_q[1];
  assign ic_idx_o  = idx_q[2];
  assign oc_idx_o  = idx_q[3];
  assign w_last_o  = last[0];
  assign h_last_o  = last[1];
  assign ic_last_o = last[2];
  assign oc_last_o = last[3];

endmodule
`default_nettype wire

// File: rtl/conv_tile_sequencer.sv
`default_nettype none
// =============================================================================
// Module : conv_tile_sequencer
// Brief  : Layer/tile control FSM: weight and input fetch, fixed-length compute bursts.
// Rev    : 1.0
// =============================================================================
module conv_tile_sequencer
  import conv_seq_pkg::*;
#(
  parameter int NUM_PE = DEF_NUM_PE,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int K_CYC  = DEF_K_CYC
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CNT_W-1:0]  cfg_w_i,
  input  logic [CNT_W-1:0]  cfg_h_i,
  input  logic [CNT_W-1:0]  cfg_ic_i,
  input  logic [CNT_W-1:0]  cfg_oc_i,
  input  logic [NUM_PE-1:0] cfg_pe_mask_i,
  input  logic              cfg_last_i,
  output logic              weight_req_o,
  input  logic              weight_ack_i,
  output logic              input_loader_req_o,
  input  logic              input_loader_ack_i,
  input  logic              compute_stall_i,
  output logic              layer_start_o,
  output logic              dataflow_en_o,
  output logic [NUM_PE-1:0] conv_vld_o,
  output logic [CNT_W-1:0]  w_idx_o,
  output logic [CNT_W-1:0]  h_idx_o,
  output logic [CNT_W-1:0]  ic_idx_o,
  output logic [CNT_W-1:0]  oc_idx_o,
  output logic              is_last_layer_o,
  output logic              layer_done_o
);

  localparam int              KC_W    = kc_width(K_CYC);
  localparam logic [KC_W-1:0] KC_LAST = KC_W'(K_CYC - 1);

  seq_state_e        state_q, state_d;
  logic [KC_W-1:0]   kc_q, kc_d;
  logic              run_q, run_d;
  logic [NUM_PE-1:0] pe_mask_q, pe_mask_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              weight_req_q, weight_req_d;
  logic              input_req_q, input_req_d;
  logic              layer_start_q, layer_start_d;
  logic              dataflow_en_q, dataflow_en_d;
  logic [NUM_PE-1:0] conv_vld_q, conv_vld_d;
  logic              is_last_q, is_last_d;
  logic              layer_done_q, layer_done_d;
  logic              accept;
  logic              burst_end;
  logic              w_last, h_last, ic_last, oc_last;

  tile_counter_chain #(
    .CNT_W (CNT_W)
  ) u_counters (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .load_i    (accept),
    .inc_i     (burst_end),
    .cnt_w_i   (cfg_w_i),
    .cnt_h_i   (cfg_h_i),
    .cnt_ic_i  (cfg_ic_i),
    .cnt_oc_i  (cfg_oc_i),
    .w_idx_o   (w_idx_o),
    .h_idx_o   (h_idx_o),
    .ic_idx_o  (ic_idx_o),
    .oc_idx_o  (oc_idx_o),
    .w_last_o  (w_last),
    .h_last_o  (h_last),
    .ic_last_o (ic_last),
    .oc_last_o (oc_last)
  );

  always_comb begin
    state_d   = state_q;
    kc_d      = kc_q;
    accept    = 1'b0;
    burst_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid_i) begin
          accept  = 1'b1;
          state_d = ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (weight_ack_i) state_d = ST_LOAD_IN;
      end
      ST_LOAD_IN: begin
        if (input_loader_ack_i) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        // run_q marks the non-stalled cycles; only those advance the burst.
        if (run_q) begin
          if (kc_q == KC_LAST) begin
            burst_end = 1'b1;
            kc_d      = '0;
            if (!w_last || !h_last) begin
              state_d = ST_LOAD_IN;
            end else if (!ic_last || !oc_last) begin
              state_d = ST_LOAD_W;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            kc_d = kc_q + KC_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pe_mask_d     = accept ? cfg_pe_mask_i : pe_mask_q;
    run_d         = (state_d == ST_COMPUTE) && !compute_stall_i;
    cfg_ready_d   = (state_d == ST_IDLE);
    weight_req_d  = (state_d == ST_LOAD_W);
    input_req_d   = (state_d == ST_LOAD_IN);
    layer_start_d = accept;
    dataflow_en_d = (state_d == ST_COMPUTE);
    conv_vld_d    = run_d ? pe_mask_d : '0;
    layer_done_d  = (state_d == ST_DONE);
    if (accept) begin
      is_last_d = cfg_last_i;
    end else if (state_d == ST_IDLE) begin
      is_last_d = 1'b0;
    end else begin
      is_last_d = is_last_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      kc_q          <= '0;
      run_q         <= 1'b0;
      pe_mask_q     <= '0;
      cfg_ready_q   <= 1'b1;
      weight_req_q  <= 1'b0;
      input_req_q   <= 1'b0;
      layer_start_q <= 1'b0;
      dataflow_en_q <= 1'b0;
      conv_vld_q    <= '0;
      is_last_q     <= 1'b0;
      layer_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      kc_q          <= kc_d;
      run_q         <= run_d;
      pe_mask_q     <= pe_mask_d;
      cfg_ready_q   <= cfg_ready_d;
      weight_req_q  <= weight_req_d;
      input_req_q   <= input_req_d;
      layer_start_q <= layer_start_d;
      dataflow_en_q <= dataflow_en_d;
      conv_vld_q    <= conv_vld_d;
      is_last_q     <= is_last_d;
      layer_done_q  <= layer_done_d;
    end
  end

  assign cfg_ready_o        = cfg_ready_q;
  assign weight_req_o       = weight_req_q;
  assign input_loader_req_o = input_req_q;
  assign layer_start_o      = layer_start_q;
  assign dataflow_en_o      = dataflow_en_q;
  assign conv_vld_o         = conv_vld_q;
  assign is_last_layer_o    = is_last_q;
  assign layer_done_o       = layer_done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_tile_sequencer.sv
`default_nettype none
// =============================================================================
// Module : tb_conv_tile_sequencer
// Brief  : Self-checking bench: per-layer expectation and tile-index scoreboards.
// Rev    : 1.0
// =============================================================================
module tb_conv_tile_sequencer;
  import conv_seq_pkg::*;

  localparam int NUM_PE = 9;
  localparam int CNT_W  = 16;
  localparam int K_CYC  = 9;

  typedef struct {
    logic [15:0] w;
    logic [15:0] h;
    logic [15:0] ic;
    logic [15:0] oc;
    logic [8:0]  mask;
    logic        last;
    int          done;
    int          wr;
    int          ir;
    int          vl;
  } vec_t;

  typedef struct {
    int       done;
    int       wr;
    int       ir;
    int       vl;
    int       df;
    logic [8:0] mask;
    logic     last;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic cfg_valid, cfg_ready, cfg_last;
  logic [CNT_W-1:0] cfg_w, cfg_h, cfg_ic, cfg_oc;
  logic [NUM_PE-1:0] cfg_pe_mask, conv_vld;
  logic weight_req, weight_ack, input_req, input_ack, compute_stall;
  logic layer_start, dataflow_en, is_last_layer, layer_done;
  logic [CNT_W-1:0] w_idx, h_idx, ic_idx, oc_idx;

  always #5 clk = ~clk;

  conv_tile_sequencer #(
    .NUM_PE (NUM_PE),
    .CNT_W  (CNT_W),
    .K_CYC  (K_CYC)
  ) dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .cfg_valid_i        (cfg_valid),
    .cfg_ready_o        (cfg_ready),
    .cfg_w_i            (cfg_w),
    .cfg_h_i            (cfg_h),
    .cfg_ic_i           (cfg_ic),
    .cfg_oc_i           (cfg_oc),
    .cfg_pe_mask_i      (cfg_pe_mask),
    .cfg_last_i         (cfg_last),
    .weight_req_o       (weight_req),
    .weight_ack_i       (weight_ack),
    .input_loader_req_o (input_req),
    .input_loader_ack_i (input_ack),
    .compute_stall_i    (compute_stall),
    .layer_start_o      (layer_start),
    .dataflow_en_o      (dataflow_en),
    .conv_vld_o         (conv_vld),
    .w_idx_o            (w_idx),
    .h_idx_o            (h_idx),
    .ic_idx_o           (ic_idx),
    .oc_idx_o           (oc_idx),
    .is_last_layer_o    (is_last_layer),
    .layer_done_o       (layer_done)
  );

  int checks   = 0;
  int failures = 0;
  exp_t lay_q[$];
  logic [63:0] tile_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected tile order: w fastest, oc slowest; zero counts act as one.
  function automatic void push_tiles(input vec_t v, input int limit);
    int n = 0;
    int cw = (v.w == 0) ? 1 : int'(v.w);
    int ch = (v.h == 0) ? 1 : int'(v.h);
    int ci = (v.ic == 0) ? 1 : int'(v.ic);
    int co = (v.oc == 0) ? 1 : int'(v.oc);
    for (int o = 0; o < co; o++)
      for (int i = 0; i < ci; i++)
        for (int y = 0; y < ch; y++)
          for (int x = 0; x < cw; x++) begin
            if (n < limit) tile_q.push_back({16'(o), 16'(i), 16'(y), 16'(x)});
            n++;
          end
  endfunction

  function automatic void push_exp(input vec_t v, input int add_done, input int add_df,
                                   input int add_wr);
    exp_t e;
    e.done = v.done + add_done;
    e.wr   = v.wr + add_wr;
    e.ir   = v.ir;
    e.vl   = v.vl;
    e.df   = v.vl + add_df;
    e.mask = v.mask;
    e.last = v.last;
    lay_q.push_back(e);
  endfunction

  task automatic drive_cfg(input vec_t v);
    cfg_w       = v.w;
    cfg_h       = v.h;
    cfg_ic      = v.ic;
    cfg_oc      = v.oc;
    cfg_pe_mask = v.mask;
    cfg_last    = v.last;
  endtask

  // Called at a negedge; returns at the negedge of the layer_start cycle.
  task automatic start_layer(input vec_t v);
    int n = 0;
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_ready_before_start", 64'(cfg_ready), 64'd1);
    drive_cfg(v);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!layer_done && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("layer_done_seen", 64'(layer_done), 64'd1);
  endtask

  // Monitor: pops the layer expectation at layer_start, compares at layer_done.
  exp_t cur;
  int t, wr, ir, vl, df, badv, badl;
  logic active  = 1'b0;
  logic df_prev = 1'b0;
  logic [63:0] tile_exp;

  always @(negedge clk) begin
    if (!rstn) begin
      active  = 1'b0;
      df_prev = 1'b0;
    end else begin
      if (layer_start) begin
        chk("start_inside_layer", 64'(active), 64'd0);
        active = 1'b1;
        t = 0; wr = 0; ir = 0; vl = 0; df = 0; badv = 0; badl = 0;
        chk("layer_queue_nonempty", 64'(lay_q.size() > 0), 64'd1);
        if (lay_q.size() > 0) cur = lay_q.pop_front();
      end
      if (layer_done) chk("done_inside_layer", 64'(active), 64'd1);
      if (active) begin
        t++;
        wr += int'(weight_req);
        ir += int'(input_req);
        df += int'(dataflow_en);
        if (conv_vld != '0) begin
          vl++;
          if (conv_vld != cur.mask || !dataflow_en) badv++;
        end
        if (is_last_layer != cur.last) badl++;
        if (dataflow_en && !df_prev) begin
          chk("tile_queue_nonempty", 64'(tile_q.size() > 0), 64'd1);
          if (tile_q.size() > 0) begin
            tile_exp = tile_q.pop_front();
            chk("tile_idx_oc_ic_h_w", {oc_idx, ic_idx, h_idx, w_idx}, tile_exp);
          end
        end
        df_prev = dataflow_en;
        if (layer_done) begin
          chk("layer_done_cycle", 64'(t), 64'(cur.done));
          chk("weight_req_cycles", 64'(wr), 64'(cur.wr));
          chk("input_req_cycles", 64'(ir), 64'(cur.ir));
          chk("conv_vld_cycles", 64'(vl), 64'(cur.vl));
          chk("dataflow_en_cycles", 64'(df), 64'(cur.df));
          chk("conv_vld_bad_value", 64'(badv), 64'd0);
          chk("is_last_layer_bad", 64'(badl), 64'd0);
          active = 1'b0;
        end
      end
    end
  end

  vec_t vecs[4];
  vec_t va, vc1, vc2, vd;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // {w, h, ic, oc, mask, last, done_cycle, weight_req, input_req, conv_vld cycles}
    vecs[0] = '{16'd2, 16'd1, 16'd1, 16'd1, 9'h1FF, 1'b0, 22, 1, 2, 18};
    vecs[1] = '{16'd2, 16'd2, 16'd2, 16'd2, 9'h0AA, 1'b0, 165, 4, 16, 144};
    vecs[2] = '{16'd0, 16'd3, 16'd1, 16'd2, 9'h001, 1'b1, 63, 2, 6, 54};
    vecs[3] = '{16'd3, 16'd1, 16'd2, 16'd1, 9'h100, 1'b0, 63, 2, 6, 54};
    va  = vecs[0];
    vc1 = '{16'd2, 16'd1, 16'd1, 16'd1, 9'h1FF, 1'b1, 22, 1, 2, 18};
    vc2 = '{16'd1, 16'd1, 16'd1, 16'd1, 9'h03C, 1'b0, 12, 1, 1, 9};
    vd  = '{16'd2, 16'd2, 16'd1, 16'd1, 9'h0F0, 1'b0, 42, 1, 4, 36};

    rstn = 1'b0; cfg_valid = 1'b0; drive_cfg(vecs[0]);
    weight_ack = 1'b1; input_ack = 1'b1; compute_stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_ctrl_outputs", 64'({weight_req, input_req, layer_start, dataflow_en,
                                 is_last_layer, layer_done}), 64'd0);
    chk("rst_conv_vld", 64'(conv_vld), 64'd0);
    chk("rst_idx", {oc_idx, ic_idx, h_idx, w_idx}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      push_exp(vecs[i], 0, 0, 0);
      push_tiles(vecs[i], 1 << 30);
      start_layer(vecs[i]);
      wait_done(400);
      @(negedge clk);
    end

    // Three stalled cycles in the first burst.
    push_exp(va, 3, 3, 0);
    push_tiles(va, 1 << 30);
    start_layer(va);
    repeat (4) @(negedge clk);
    compute_stall = 1'b1;
    repeat (3) @(negedge clk);
    compute_stall = 1'b0;
    wait_done(100);
    @(negedge clk);

    // Weight ack late by five cycles while an unsolicited input ack is held high.
    push_exp(va, 5, 0, 5);
    push_tiles(va, 1 << 30);
    weight_ack = 1'b0;
    start_layer(va);
    repeat (5) @(negedge clk);
    weight_ack = 1'b1;
    wait_done(100);
    @(negedge clk);

    // Config offered mid-layer is ignored, then taken right after layer_done.
    push_exp(vc1, 0, 0, 0);
    push_tiles(vc1, 1 << 30);
    push_exp(vc2, 0, 0, 0);
    push_tiles(vc2, 1 << 30);
    start_layer(vc1);
    repeat (4) @(negedge clk);
    drive_cfg(vc2);
    cfg_valid = 1'b1;
    wait_done(100);
    @(negedge clk);
    chk("idle_after_done_ready", 64'(cfg_ready), 64'd1);
    chk("idle_after_done_last", 64'(is_last_layer), 64'd0);
    @(negedge clk);
    chk("back_to_back_start", 64'(layer_start), 64'd1);
    cfg_valid = 1'b0;
    wait_done(100);
    @(negedge clk);

    // Reset during the fourth tile's burst.
    push_exp(vd, 0, 0, 0);
    push_tiles(vd, 4);
    start_layer(vd);
    repeat (34) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("midrst_ctrl_outputs", 64'({weight_req, input_req, layer_start, dataflow_en,
                                    is_last_layer, layer_done}), 64'd0);
    chk("midrst_conv_vld", 64'(conv_vld), 64'd0);
    chk("midrst_idx", {oc_idx, ic_idx, h_idx, w_idx}, 64'd0);
    chk("midrst_tiles_seen", 64'(tile_q.size()), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    push_exp(vecs[1], 0, 0, 0);
    push_tiles(vecs[1], 1 << 30);
    start_layer(vecs[1]);
    wait_done(400);
    repeat (2) @(negedge clk);

    chk("layer_queue_drained", 64'(lay_q.size()), 64'd0);
    chk("tile_queue_drained", 64'(tile_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
